// File: rtl/uart_byte_fifo.sv
// Elastic byte FIFO between the UART receiver (ready/ack) and transmitter (write/busy).
// Receive bursts are absorbed while the transmitter is busy; full applies backpressure.
module uart_byte_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  rx_ready_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    output logic                  rx_ack_o,
    input  logic                  tx_busy_i,
    output logic                  tx_write_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [0:0] RX_IDLE  = 1'b0;
    localparam logic [0:0] RX_ACK   = 1'b1;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_WAIT  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            rx_state_q, rx_state_d;
    logic [1:0]            tx_state_q, tx_state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  rx_ack_q, rx_ack_d;
    logic                  tx_write_q, tx_write_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  push;
    logic                  pop;

    // Push is gated by the registered full flag, so a push never lands in a full array.
    // NOTE: every always_comb output gets a default first; a missing branch would infer a latch.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_ack_d   = rx_ack_q;
        push       = 1'b0;
        if (rx_state_q == RX_IDLE) begin
            if (rx_ready_i && !full_q) begin
                push       = 1'b1;
                rx_ack_d   = 1'b1;
                rx_state_d = RX_ACK;
            end
        end else if (!rx_ready_i) begin
            rx_ack_d   = 1'b0;
            rx_state_d = RX_IDLE;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!empty_q && !tx_busy_i) begin
                    pop        = 1'b1;
                    tx_write_d = 1'b1;
                    tx_data_d  = mem[rd_ptr_q];
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_busy_i)  tx_state_d = TX_WAIT;
            TX_WAIT:  if (!tx_busy_i) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_COUNT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rx_ack_q   <= 1'b0;
            tx_write_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rx_ack_q   <= rx_ack_d;
            tx_write_q <= tx_write_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr_q] <= rx_data_i;
    end

    assign rx_ack_o   = rx_ack_q;
    assign tx_write_o = tx_write_q;
    assign tx_data_o  = tx_data_q;
    assign count_o    = count_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo: receiver and transmitter handshake models driven
// cycle by cycle, with an independent occupancy model and an output byte log.
module tb_uart_byte_fifo;

    logic       clock_i    = 1'b0;
    logic       reset_i    = 1'b0;
    logic       rx_ready_i = 1'b0;
    logic [7:0] rx_data_i  = 8'h00;
    logic       tx_busy_i  = 1'b0;
    logic       rx_ack_o;
    logic       tx_write_o;
    logic [7:0] tx_data_o;
    logic [4:0] count_o;
    logic       empty_o;
    logic       full_o;

    uart_byte_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .rx_ready_i (rx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_ack_o   (rx_ack_o),
        .tx_busy_i  (tx_busy_i),
        .tx_write_o (tx_write_o),
        .tx_data_o  (tx_data_o),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o)
    );

    always #5 clock_i = ~clock_i;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] rx_mem [64];
    int         rx_idx, rx_total;
    bit         tx_auto, busy_force;
    int         frame, busy_left;
    logic [7:0] out_q [$];
    int         model_cnt;
    logic       prev_ack, prev_wr;
    int         base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Log every transmit pulse and track occupancy from the handshakes alone.
    task automatic monitor();
        logic push, pop;
        if (reset_i) begin
            model_cnt = 0;
            prev_ack  = 1'b0;
            prev_wr   = 1'b0;
        end else begin
            push = rx_ack_o && !prev_ack;
            pop  = tx_write_o;
            if (pop) begin
                check("wr_pulse", prev_wr, 0);
                out_q.push_back(tx_data_o);
            end
            model_cnt = model_cnt + int'(push) - int'(pop);
            if (push || pop) begin
                check("cnt", count_o, model_cnt);
                check("empty", empty_o, model_cnt == 0);
                check("full", full_o, model_cnt == 16);
            end
            prev_ack = rx_ack_o;
            prev_wr  = tx_write_o;
        end
    endtask

    // One clock: drive the peer models just after the edge, observe at the falling edge.
    task automatic step();
        @(posedge clock_i);
        #1;
        if (rx_ready_i && rx_ack_o) begin
            rx_ready_i = 1'b0;
        end else if (!rx_ready_i && !rx_ack_o && rx_idx < rx_total) begin
            rx_data_i  = rx_mem[rx_idx];
            rx_idx++;
            rx_ready_i = 1'b1;
        end
        if (!tx_auto) begin
            tx_busy_i = busy_force;
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy_i = 1'b0;
        end else if (tx_write_o) begin
            tx_busy_i = 1'b1;
            busy_left = frame;
        end else begin
            tx_busy_i = 1'b0;
        end
        @(negedge clock_i);
        monitor();
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, out_q.size(), n);
    endtask

    task automatic load_rx(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) rx_mem[i] = first + 8'(i);
        rx_idx   = 0;
        rx_total = n;
    endtask

    initial begin
        int k;
        rx_idx = 0; rx_total = 0; tx_auto = 0; busy_force = 0;
        frame = 3; busy_left = 0; model_cnt = 0; prev_ack = 0; prev_wr = 0;

        // Asynchronous reset before any clock edge.
        #3 reset_i = 1'b1;
        #1;
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_write", tx_write_o, 0);
        check("rst_ack", rx_ack_o, 0);
        check("rst_data", tx_data_o, 0);
        repeat (2) step();
        reset_i = 1'b0;
        repeat (2) step();

        // Single byte: ack one edge after ready is sampled, write one edge later.
        tx_auto = 1; frame = 3;
        base = out_q.size();
        load_rx(1, 8'hA5);
        step();
        check("sb_ack_early", rx_ack_o, 0);
        step();
        check("sb_ack", rx_ack_o, 1);
        check("sb_count1", count_o, 1);
        check("sb_wr_early", tx_write_o, 0);
        step();
        check("sb_write", tx_write_o, 1);
        check("sb_data", tx_data_o, 8'hA5);
        check("sb_count0", count_o, 0);
        check("sb_ack_fall", rx_ack_o, 0);
        step();
        check("sb_wr_once", tx_write_o, 0);
        repeat (8) step();
        check("sb_nout", out_q.size(), base + 1);

        // Fill with the transmitter busy; the 17th byte must wait for a free slot.
        tx_auto = 0; busy_force = 1;
        base = out_q.size();
        load_rx(17, 8'h00);
        repeat (45) step();
        check("fill_full", full_o, 1);
        check("fill_count", count_o, 16);
        check("fill_empty", empty_o, 0);
        check("fill_noack", rx_ack_o, 0);
        repeat (5) step();
        check("bp_hold_ack", rx_ack_o, 0);
        check("bp_hold_cnt", count_o, 16);
        tx_auto = 1; frame = 4; busy_force = 0;
        wait_out(base + 17, 300, "fill_drain");
        repeat (8) step();
        check("fill_cnt_end", count_o, 0);
        check("fill_empty_end", empty_o, 1);
        for (int i = 0; i < 17; i++)
            if (base + i < out_q.size()) check("fill_order", out_q[base + i], i);

        // Stream 40 bytes against a transmitter finishing a frame every 10 cycles.
        frame = 8;
        base = out_q.size();
        load_rx(40, 8'h30);
        wait_out(base + 40, 1500, "wrap_drain");
        repeat (12) step();
        check("wrap_cnt_end", count_o, 0);
        for (int i = 0; i < 40; i++)
            if (base + i < out_q.size()) check("wrap_order", out_q[base + i], 8'h30 + i);

        // Busy handshake: no second write until busy has risen and fallen.
        tx_auto = 0; busy_force = 0;
        repeat (3) step();
        base = out_q.size();
        load_rx(3, 8'h71);
        k = 0;
        while (out_q.size() == base && k < 20) begin
            step();
            k++;
        end
        check("bh_first", out_q.size(), base + 1);
        check("bh_first_data", tx_data_o, 8'h71);
        repeat (5) step();
        busy_force = 1;
        repeat (20) step();
        check("bh_no_write", out_q.size(), base + 1);
        check("bh_queued", count_o, 2);
        busy_force = 0;
        step();
        rx_mem[3] = 8'h74;
        rx_total  = 4;
        tx_auto = 1; frame = 3;
        step();
        check("bh_idle_wr", tx_write_o, 0);
        check("bh_idle_cnt", count_o, 2);
        step();
        check("bh_write", tx_write_o, 1);
        check("bh_data", tx_data_o, 8'h72);
        check("bh_pushpop_ack", rx_ack_o, 1);
        check("bh_pushpop_cnt", count_o, 2);
        wait_out(base + 4, 100, "bh_drain");
        repeat (8) step();
        check("bh_cnt_end", count_o, 0);
        for (int i = 0; i < 4; i++)
            if (base + i < out_q.size()) check("bh_order", out_q[base + i], 8'h71 + i);

        // Reset mid-operation: bytes queued, ack high, frame in flight.
        tx_auto = 1; frame = 30;
        load_rx(6, 8'h81);
        k = 0;
        while (!(count_o == 5 && rx_ack_o) && k < 60) begin
            step();
            k++;
        end
        check("rm_reach", count_o == 5 && rx_ack_o, 1);
        reset_i = 1'b1;
        #1;
        check("rm_count", count_o, 0);
        check("rm_empty", empty_o, 1);
        check("rm_full", full_o, 0);
        check("rm_ack", rx_ack_o, 0);
        check("rm_write", tx_write_o, 0);
        check("rm_data", tx_data_o, 0);
        rx_ready_i = 1'b0;
        rx_idx     = rx_total;
        tx_auto    = 0;
        busy_force = 0;
        repeat (2) step();
        reset_i = 1'b0;
        repeat (2) step();
        check("rm_post_cnt", count_o, 0);
        base = out_q.size();
        load_rx(1, 8'h5A);
        tx_auto = 1; frame = 3;
        repeat (20) step();
        check("rm_nout", out_q.size(), base + 1);
        if (base < out_q.size()) check("rm_byte", out_q[base], 8'h5A);
        check("rm_cnt_end", count_o, 0);
        check("rm_empty_end", empty_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_byte_fifo.md
# uart_byte_fifo

Elastic byte buffer between the UART receiver and the UART transmitter in the loopback path. It accepts bytes from the receiver's ready/ack handshake, stores up to 2^DEPTH_LOG2 of them in order, and feeds them to the transmitter's write/busy handshake. Its purpose is to absorb receive bursts while the transmitter is busy, so no byte is lost when the peer sends back-to-back frames.

## Interface
- DATA_WIDTH, 8: byte width.
- DEPTH_LOG2, 4: log2 of storage depth; depth = 16 by default.
- clock_i  input  1  system clock; all state changes on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- rx_ready_i  input  1  receiver holds a valid byte; stays high until acknowledged.
- rx_data_i  input  DATA_WIDTH  received byte; stable while rx_ready_i is high.
- rx_ack_o  output  1  byte consumed; receiver clears rx_ready_i in response.
- tx_busy_i  input  1  transmitter is sending a frame.
- tx_write_o  output  1  one-cycle pulse that starts a transmit of tx_data_o.
- tx_data_o  output  DATA_WIDTH  byte to transmit; held until the next tx_write_o.
- count_o  output  DEPTH_LOG2+1  bytes currently stored, 0..2^DEPTH_LOG2.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == 2^DEPTH_LOG2.

## Operation
- Storage: circular array, write pointer and read pointer each DEPTH_LOG2 bits. Pointers wrap modulo depth without special handling. count_o is a separate register.
- Receive FSM, RX_IDLE / RX_ACK:
  - RX_IDLE: if rx_ready_i && !full_o, write rx_data_i at the write pointer, increment the write pointer, set rx_ack_o=1, and go to RX_ACK.
  - RX_IDLE: if rx_ready_i && full_o, do nothing. The byte stays pending at the receiver (backpressure) and no ack is issued.
  - RX_ACK: hold rx_ack_o=1 while rx_ready_i is high. When rx_ready_i is low, clear rx_ack_o and return to RX_IDLE.
  - A byte is never pushed twice.
- Transmit FSM, TX_IDLE / TX_START / TX_WAIT:
  - TX_IDLE: if !empty_o && !tx_busy_i, load tx_data_o from the read pointer, increment the read pointer, pulse tx_write_o=1, and go to TX_START.
  - TX_START: tx_write_o=0. Wait for tx_busy_i=1, then go to TX_WAIT.
  - TX_WAIT: wait for tx_busy_i=0, then go to TX_IDLE.
- Count: +1 on a push, -1 on a pop, unchanged on a simultaneous push and pop. Push is blocked only by full; pop is blocked only by empty. A pop and a push in the same cycle when full_o=1 is impossible, because the push condition is evaluated on the pre-edge full_o.
- Ordering is strictly FIFO. No bytes are dropped or duplicated.
- Reset (asserted at any time, including mid-handshake or mid-frame):
  - Pointers and count go to 0; both FSMs go to idle.
  - rx_ack_o=0, tx_write_o=0, tx_data_o=0, count_o=0, empty_o=1, full_o=0.
  - Stored bytes are discarded. Memory contents are don't-care.

## Timing
- Edge N samples rx_ready_i=1 with space. After edge N: rx_ack_o=1 and count_o has incremented.
- Edge N+1 (tx idle, tx_busy_i=0): after this edge, tx_write_o=1 and tx_data_o=byte. Minimum latency from ready to write is 2 edges.
- tx_write_o is high for exactly one cycle. A second write is not issued until tx_busy_i has been observed high and then low again.
- rx_ack_o falls on the first edge after rx_ready_i is sampled low.
- empty_o and full_o are registered, coherent with count_o, and never glitch.

## Test plan
- Reset values: assert reset_i asynchronously between edges. All outputs take their reset values immediately: count_o=0, empty_o=1, tx_write_o=0.
- Single byte: rx_data_i=0xA5, rx_ready_i until ack, tx_busy_i=0 → rx_ack_o 1 cycle after ready sampled; tx_write_o pulses 2 edges after, tx_data_o=0xA5; count_o returns to 0.
- Fill/backpressure: tx_busy_i held 1, push 0x00..0x0F → full_o=1, count_o=16; a 17th byte 0x10 gets no rx_ack_o. Release tx_busy_i → the first pop frees a slot, 0x10 is acked, and output order is 0x00..0x10.
- Wrap and concurrency: stream 40 bytes (0x30+i) while the transmitter model finishes frames every 10 cycles. A pointer wraps at least twice, a simultaneous push+pop keeps count_o steady, and output order matches the input.
- Busy handshake: after tx_write_o, hold tx_busy_i=0 for 5 cycles, then 1 for 20, then 0 with bytes queued → no second tx_write_o until tx_busy_i falls.
- Reset mid-operation: 5 bytes queued, rx_ack_o high, frame in flight, assert reset_i → everything cleared. After release, a new byte 0x5A passes through alone.
